// File: rtl/serdes_8b10b_link_init.sv
// Link bring-up and supervision FSM for an 8b/10b serial link in the clk_byte domain.
// Qualifies MMCM lock, sequences datapath resets, trains on commas and supervises error bursts.
module serdes_8b10b_link_init #(
    parameter int unsigned LOCK_WAIT_CYCLES = 256,
    parameter int unsigned RST_HOLD_CYCLES  = 16,
    parameter int unsigned ALIGN_COMMAS     = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 65536,
    parameter int unsigned ERR_WINDOW       = 1024,
    parameter int unsigned ERR_THRESH       = 8
) (
    input  logic        clk_byte,
    input  logic        rst_n,
    input  logic        mmcm_locked,
    input  logic        rx_data_valid,
    input  logic        rx_comma_det,
    input  logic        rx_code_err,
    input  logic        rx_disp_err,
    output logic        tx_rst_n,
    output logic        rx_rst_n,
    output logic        tx_send_training,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [7:0]  retrain_cnt,
    output logic [15:0] err_total
);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StHoldRst  = 3'd1,
        StAlign    = 3'd2,
        StLinkUp   = 3'd3,
        StFault    = 3'd4
    } state_e;

    // One shared per-state timer serves lock qualify, reset hold, align timeout and error window.
    localparam int unsigned TMAX_A = (LOCK_WAIT_CYCLES > RST_HOLD_CYCLES) ?
                                     LOCK_WAIT_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned TMAX_B = (TIMEOUT_CYCLES > ERR_WINDOW) ? TIMEOUT_CYCLES : ERR_WINDOW;
    localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int unsigned TW     = $clog2(TMAX);
    localparam int unsigned CW     = $clog2(ALIGN_COMMAS + 1);
    localparam int unsigned EW     = $clog2(ERR_THRESH + 1);

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   comma_q, comma_d;
    logic [EW-1:0]   errc_q, errc_d;
    logic [7:0]      retrain_q, retrain_d;
    logic [15:0]     err_total_q, err_total_d;
    logic            tx_rst_n_q, tx_rst_n_d;
    logic            rx_rst_n_q, rx_rst_n_d;
    logic            training_q, training_d;
    logic            link_up_q, link_up_d;

    logic lock_s;
    logic err;
    logic clean_comma;

    assign lock_s      = sync_q[1];
    assign err         = rx_data_valid & (rx_code_err | rx_disp_err);
    assign clean_comma = rx_data_valid & rx_comma_det & ~err;

    always_comb begin
        sync_d      = {sync_q[0], mmcm_locked};
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        comma_d     = comma_q;
        errc_d      = errc_q;
        retrain_d   = retrain_q;
        err_total_d = err_total_q;

        if (state_q == StLinkUp && err && err_total_q != 16'hFFFF) begin
            err_total_d = err_total_q + 16'd1;
        end

        if (!lock_s && state_q != StWaitLock) begin
            state_d = StWaitLock;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    if (!lock_s) begin
                        timer_d = '0;
                    end else if (timer_q == TW'(LOCK_WAIT_CYCLES - 1)) begin
                        state_d = StHoldRst;
                    end
                end
                StHoldRst, StFault: begin
                    if (timer_q == TW'(RST_HOLD_CYCLES - 1)) begin
                        state_d = StAlign;
                    end
                end
                StAlign: begin
                    if (err) begin
                        comma_d = '0;
                    end else if (clean_comma) begin
                        if (comma_q == CW'(ALIGN_COMMAS - 1)) begin
                            state_d = StLinkUp;
                        end else begin
                            comma_d = comma_q + CW'(1);
                        end
                    end
                    // The final comma beats a coincident timeout.
                    if (state_d != StLinkUp && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = StFault;
                    end
                end
                StLinkUp: begin
                    if (timer_q == TW'(ERR_WINDOW - 1)) begin
                        timer_d = '0;
                        errc_d  = err ? EW'(1) : '0;
                    end else if (err) begin
                        if (errc_q == EW'(ERR_THRESH - 1)) begin
                            state_d = StFault;
                        end else begin
                            errc_d = errc_q + EW'(1);
                        end
                    end
                end
                default: state_d = StWaitLock;
            endcase
        end

        if (state_d != state_q) begin
            timer_d = '0;
            comma_d = '0;
            errc_d  = '0;
            if (state_d == StFault && retrain_q != 8'hFF) begin
                retrain_d = retrain_q + 8'd1;
            end
        end

        // Outputs follow the next state so they are registered alongside it.
        unique case (state_d)
            StHoldRst: {tx_rst_n_d, rx_rst_n_d, training_d, link_up_d} = 4'b1010;
            StAlign:   {tx_rst_n_d, rx_rst_n_d, training_d, link_up_d} = 4'b1110;
            StLinkUp:  {tx_rst_n_d, rx_rst_n_d, training_d, link_up_d} = 4'b1101;
            StFault:   {tx_rst_n_d, rx_rst_n_d, training_d, link_up_d} = 4'b1010;
            default:   {tx_rst_n_d, rx_rst_n_d, training_d, link_up_d} = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_byte or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitLock;
            sync_q      <= '0;
            timer_q     <= '0;
            comma_q     <= '0;
            errc_q      <= '0;
            retrain_q   <= '0;
            err_total_q <= '0;
            tx_rst_n_q  <= 1'b0;
            rx_rst_n_q  <= 1'b0;
            training_q  <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            timer_q     <= timer_d;
            comma_q     <= comma_d;
            errc_q      <= errc_d;
            retrain_q   <= retrain_d;
            err_total_q <= err_total_d;
            tx_rst_n_q  <= tx_rst_n_d;
            rx_rst_n_q  <= rx_rst_n_d;
            training_q  <= training_d;
            link_up_q   <= link_up_d;
        end
    end

    assign state            = state_q;
    assign tx_rst_n         = tx_rst_n_q;
    assign rx_rst_n         = rx_rst_n_q;
    assign tx_send_training = training_q;
    assign link_up          = link_up_q;
    assign retrain_cnt      = retrain_q;
    assign err_total        = err_total_q;

endmodule

// File: tb/tb_serdes_8b10b_link_init.sv
// Bench for serdes_8b10b_link_init: directed phases with randomized characters, every cycle
// compared against an event-level model of the link rules.
module tb_serdes_8b10b_link_init;

    localparam int LW  = 8;
    localparam int RH  = 4;
    localparam int AC  = 4;
    localparam int TO  = 100;
    localparam int WIN = 32;
    localparam int TH  = 3;

    logic        clk_byte = 1'b0;
    logic        rst_n;
    logic        mmcm_locked;
    logic        rx_data_valid, rx_comma_det, rx_code_err, rx_disp_err;
    logic        tx_rst_n, rx_rst_n, tx_send_training, link_up;
    logic [2:0]  state;
    logic [7:0]  retrain_cnt;
    logic [15:0] err_total;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: current state, cycles already spent in it, and per-window error tallies.
    int m_st, m_age, m_run, m_commas, m_retrain, m_total;
    int win_errs[int];
    bit h0, h1;

    serdes_8b10b_link_init #(
        .LOCK_WAIT_CYCLES(LW), .RST_HOLD_CYCLES(RH), .ALIGN_COMMAS(AC),
        .TIMEOUT_CYCLES(TO), .ERR_WINDOW(WIN), .ERR_THRESH(TH)
    ) dut (
        .clk_byte(clk_byte), .rst_n(rst_n), .mmcm_locked(mmcm_locked),
        .rx_data_valid(rx_data_valid), .rx_comma_det(rx_comma_det),
        .rx_code_err(rx_code_err), .rx_disp_err(rx_disp_err),
        .tx_rst_n(tx_rst_n), .rx_rst_n(rx_rst_n), .tx_send_training(tx_send_training),
        .link_up(link_up), .state(state), .retrain_cnt(retrain_cnt), .err_total(err_total)
    );

    always #5 clk_byte = ~clk_byte;

    task automatic chk(input string tag, input logic [30:0] got, input logic [30:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_age = 0; m_run = 0; m_commas = 0; m_retrain = 0; m_total = 0;
        win_errs.delete();
        h0 = 0; h1 = 0;
    endtask

    task automatic model_edge();
        bit ls, e, cc;
        int nxt, w;
        ls = h0; h0 = h1; h1 = mmcm_locked;
        e  = rx_data_valid && (rx_code_err || rx_disp_err);
        cc = rx_data_valid && rx_comma_det && !e;
        nxt = m_st;
        if (m_st == 3 && e && m_total < 65535) m_total++;
        if (!ls && m_st != 0) nxt = 0;
        else case (m_st)
            0: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == LW) nxt = 1;
            end
            1, 4: if (m_age + 1 == RH) nxt = 2;
            2: begin
                if (e) m_commas = 0;
                else if (cc) m_commas++;
                if (m_commas == AC) nxt = 3;
                else if (m_age + 1 == TO) nxt = 4;
            end
            3: if (e) begin
                // An error on the last cycle of a window already belongs to the next one.
                w = (m_age + 1) / WIN;
                win_errs[w] = win_errs.exists(w) ? win_errs[w] + 1 : 1;
                if (win_errs[w] >= TH) nxt = 4;
            end
            default: nxt = 0;
        endcase
        if (nxt != m_st) begin
            m_age = 0; m_run = 0; m_commas = 0;
            win_errs.delete();
            if (nxt == 4 && m_retrain < 255) m_retrain++;
            m_st = nxt;
        end else begin
            m_age++;
        end
    endtask

    function automatic logic [30:0] exp_vec();
        logic [3:0] o;
        case (m_st)
            1: o = 4'b1010;
            2: o = 4'b1110;
            3: o = 4'b1101;
            4: o = 4'b1010;
            default: o = 4'b0000;
        endcase
        return {3'(m_st), o, 8'(m_retrain), 16'(m_total)};
    endfunction

    function automatic logic [30:0] act_vec();
        return {state, tx_rst_n, rx_rst_n, tx_send_training, link_up, retrain_cnt, err_total};
    endfunction

    task automatic step();
        @(posedge clk_byte);
        model_edge();
        #1;
        chk("cycle", act_vec(), exp_vec());
    endtask

    task automatic set_in(input bit dv, input bit cm, input bit ce, input bit de);
        rx_data_valid = dv; rx_comma_det = cm; rx_code_err = ce; rx_disp_err = de;
    endtask

    // Idle or clean non-comma characters; error flags on invalid slots must be ignored.
    task automatic filler(input int n);
        repeat (n) begin
            if ($urandom_range(0, 1) == 1) set_in(1, 0, 0, 0);
            else set_in(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            step();
        end
    endtask

    task automatic clean_any();
        if ($urandom_range(0, 1) == 1) set_in(1, 1'($urandom_range(0, 1)), 0, 0);
        else set_in(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        step();
    endtask

    task automatic clean_comma();
        set_in(1, 1, 0, 0);
        step();
    endtask

    task automatic err_char();
        bit [1:0] k;
        k = 2'($urandom_range(1, 3));
        set_in(1, 1'($urandom_range(0, 1)), k[1], k[0]);
        step();
    endtask

    task automatic bring_up();
        repeat (AC) begin
            filler($urandom_range(0, 2));
            clean_comma();
        end
    endtask

    int wa[6];
    int wb[6];

    initial begin
        rst_n = 1'b0;
        mmcm_locked = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset_outputs", act_vec(), 31'd0);
        @(negedge clk_byte);
        rst_n = 1'b1;

        // Lock qualification and reset sequencing.
        mmcm_locked = 1'b1;
        filler(9);
        chk("still_wait_lock", 31'(state), 31'd0);
        filler(1);
        chk("hold_rst_entry", 31'(state), 31'd1);
        chk("hold_rx_rst_low", 31'({tx_rst_n, rx_rst_n}), 31'b10);
        filler(3);
        chk("hold_rst_length", 31'(state), 31'd1);
        filler(1);
        chk("align_entry", 31'(state), 31'd2);
        chk("align_rx_rst_high", 31'(rx_rst_n), 31'd1);
        filler(5);
        chk("no_link_without_commas", 31'(link_up), 31'd0);

        // Three commas, an error, then four commas.
        repeat (3) begin filler($urandom_range(0, 2)); clean_comma(); end
        set_in(1, 1, 1, 0); step();
        repeat (3) begin filler($urandom_range(0, 2)); clean_comma(); end
        chk("no_link_after_6", 31'(link_up), 31'd0);
        clean_comma();
        chk("link_up_after_7", 31'(link_up), 31'd1);

        // Error burst: three errors inside one window.
        repeat (3) begin
            repeat ($urandom_range(1, 5)) clean_any();
            err_char();
        end
        chk("burst_fault", 31'(state), 31'd4);
        chk("burst_link_down", 31'(link_up), 31'd0);
        chk("burst_err_total", 31'(err_total), 31'd3);
        chk("burst_retrain", 31'(retrain_cnt), 31'd1);
        filler(3);
        chk("fault_rx_rst_low", 31'(rx_rst_n), 31'd0);
        filler(1);
        chk("fault_to_align", 31'(state), 31'd2);

        // Alignment timeout: no valid commas at all.
        repeat (TO - 1) begin
            if ($urandom_range(0, 3) == 0) err_char();
            else filler(1);
        end
        chk("align_before_timeout", 31'(state), 31'd2);
        filler(1);
        chk("timeout_fault", 31'(state), 31'd4);
        chk("timeout_retrain", 31'(retrain_cnt), 31'd2);
        filler(RH);
        chk("timeout_back_align", 31'(state), 31'd2);

        // Two errors per window for five windows.
        bring_up();
        chk("relink", 31'(link_up), 31'd1);
        for (int k = 0; k < 6; k++) begin
            wa[k] = $urandom_range(1, 15);
            wb[k] = $urandom_range(16, 31);
        end
        for (int t = 0; t < 5 * WIN - 1; t++) begin
            if ((t + 1) % WIN == wa[(t + 1) / WIN] || (t + 1) % WIN == wb[(t + 1) / WIN])
                err_char();
            else clean_any();
        end
        chk("windows_link_up", 31'(link_up), 31'd1);
        chk("windows_err_total", 31'(err_total), 31'd13);

        // Error on the wrap cycle opens the next window.
        err_char();
        clean_any();
        err_char();
        chk("wrap_still_up", 31'(state), 31'd3);
        err_char();
        chk("wrap_fault", 31'(state), 31'd4);
        chk("wrap_err_total", 31'(err_total), 31'd16);
        chk("wrap_retrain", 31'(retrain_cnt), 31'd3);

        // Lock loss while in service.
        filler(RH);
        bring_up();
        chk("link_before_unlock", 31'(link_up), 31'd1);
        mmcm_locked = 1'b0;
        filler(3);
        chk("unlock_state", 31'(state), 31'd0);
        chk("unlock_outputs", 31'({tx_rst_n, rx_rst_n, tx_send_training, link_up}), 31'd0);
        chk("unlock_retrain_kept", 31'(retrain_cnt), 31'd3);

        // Asynchronous reset mid-ALIGN.
        mmcm_locked = 1'b1;
        filler(2 + LW + RH + 3);
        chk("align_before_rst", 31'(state), 31'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", act_vec(), 31'd0);
        model_reset();
        #3;
        rst_n = 1'b1;

        // Free-running random traffic with occasional lock glitches.
        for (int i = 0; i < 600; i++) begin
            mmcm_locked = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 9))
                0: err_char();
                1, 2, 3, 4: clean_comma();
                default: clean_any();
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
